muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 157 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for an external multiplier and divider: latches operands,
// issues a start pulse, waits for the selected unit's done and loads HI/LO.
module muldiv_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi_wr,
    input  logic        mtlo_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mult_start,
    output logic        div_start,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        mult_done,
    input  logic        div_done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout_err
);

    // state | meaning
    // IDLE  | accepts op_start and mthi/mtlo writes
    // START | one-cycle start pulse to the selected unit
    // WAIT  | watches the selected done flag, bounded by TIMEOUT cycles
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sel;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0]   r_unit_a;
    logic [31:0]   r_unit_b;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_done;
    logic          r_div_zero;
    logic          r_timeout;
    logic          w_accept;
    logic          w_dz;
    logic          w_fin;
    logic          w_tmo;
    logic          w_sel_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_dz        = 1'b0;
        w_fin       = 1'b0;
        w_tmo       = 1'b0;
        w_sel_done  = r_sel ? div_done : mult_done;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (op_start) begin
                    if (op_div && (op_b == 32'd0)) begin
                        w_dz = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // done on the last permitted cycle still counts as success
                if (w_sel_done) begin
                    w_fin       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel      <= 1'b0;
            r_unit_a   <= '0;
            r_unit_b   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done     <= w_fin;
            r_div_zero <= w_dz;
            r_timeout  <= w_tmo;
            if (w_accept) begin
                r_unit_a <= op_a;
                r_unit_b <= op_b;
                r_sel    <= op_div;
            end
            // direct writes only land while idle; a result later overwrites them
            if (r_state == S_IDLE) begin
                if (mthi_wr) r_hi <= wr_data;
                if (mtlo_wr) r_lo <= wr_data;
            end
            if (w_fin) begin
                r_hi <= r_sel ? div_hi : mult_hi;
                r_lo <= r_sel ? div_lo : mult_lo;
            end
        end
    end

    assign unit_a      = r_unit_a;
    assign unit_b      = r_unit_b;
    assign mult_start  = (r_state == S_START) && !r_sel;
    assign div_start   = (r_state == S_START) && r_sel;
    assign busy        = (r_state != S_IDLE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign done        = r_done;
    assign div_zero    = r_div_zero;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with simple multiplier/divider unit models.
module tb_muldiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_start, op_div;
    logic [31:0] op_a, op_b;
    logic        mthi_wr, mtlo_wr;
    logic [31:0] wr_data;
    logic [31:0] unit_a, unit_b;
    logic        mult_start, div_start;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic        mult_done, div_done;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero, timeout_err;

    logic        m_done, d_done, noise;
    int          m_cnt, d_cnt, m_dly, d_dly;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    assign mult_done = m_done | noise;
    assign div_done  = d_done;

    muldiv_ctrl #(.TIMEOUT(64)) dut (
        .clock(clock), .reset(reset), .op_start(op_start), .op_div(op_div),
        .op_a(op_a), .op_b(op_b), .mthi_wr(mthi_wr), .mtlo_wr(mtlo_wr),
        .wr_data(wr_data), .unit_a(unit_a), .unit_b(unit_b),
        .mult_start(mult_start), .div_start(div_start),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
        .mult_done(mult_done), .div_done(div_done), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero), .timeout_err(timeout_err)
    );

    // Unit models: done rises m_dly/d_dly cycles after the start pulse's cycle + 1;
    // a delay of 0 means the unit never finishes. Not affected by reset.
    always @(posedge clock) begin
        if (mult_start) begin
            m_done <= 1'b0;
            m_cnt  <= m_dly;
        end else if (m_cnt == 1) begin
            m_cnt  <= 0;
            m_done <= 1'b1;
            {mult_hi, mult_lo} <= {{32{unit_a[31]}}, unit_a} * {{32{unit_b[31]}}, unit_b};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clock) begin
        if (div_start) begin
            d_done <= 1'b0;
            d_cnt  <= d_dly;
        end else if (d_cnt == 1) begin
            d_cnt  <= 0;
            d_done <= 1'b1;
            div_hi <= unit_a % unit_b;
            div_lo <= unit_a / unit_b;
        end else if (d_cnt != 0) begin
            d_cnt <= d_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (noise !== 1'bx && d_cnt != 0) noise = ~noise;
        end
    endtask

    task automatic issue(input logic dv, input logic [31:0] a, input logic [31:0] b);
        op_start = 1'b1; op_div = dv; op_a = a; op_b = b;
    endtask

    // Returns cycles from the current cycle until done is seen, or -1 on expiry.
    task automatic wait_done(input int lim, output int cyc);
        cyc = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    int bad, cnt, cyc;

    initial begin
        reset = 1'b1; op_start = 1'b1; op_div = 1'b0; op_a = 32'h5; op_b = 32'h6;
        mthi_wr = 1'b1; mtlo_wr = 1'b1; wr_data = 32'hDEAD;
        m_done = 1'b0; d_done = 1'b0; noise = 1'b0;
        m_cnt = 0; d_cnt = 0; m_dly = 32; d_dly = 9;
        mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
        tick(2);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_unit", {unit_a, unit_b}, 64'h0);
        chk("rst_flags", {mult_start, div_start, busy, done, div_zero, timeout_err}, 0);
        reset = 1'b0; op_start = 1'b0; mthi_wr = 1'b0; mtlo_wr = 1'b0;
        tick();
        chk("idle_after_rst", {busy, hi, lo}, 0);

        // Mult 7 x -3, Booth-style 32-iteration latency
        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        tick();
        op_start = 1'b0;
        chk("mul_start_t1", {mult_start, div_start, busy}, 3'b101);
        chk("mul_unit", {unit_a, unit_b}, {32'd7, 32'hFFFF_FFFD});
        bad = 0;
        for (int k = 2; k <= 34; k++) begin
            tick();
            if (!busy || done || mult_start || div_start || unit_a != 32'd7) bad++;
        end
        chk("mul_wait_cycles", bad, 0);
        tick();
        chk("mul_done_t35", {done, busy}, 2'b10);
        chk("mul_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Div 100/7 issued in the done cycle, with mult_done noise
        issue(1'b1, 32'd100, 32'd7);
        tick();
        op_start = 1'b0;
        chk("div_start_t1", {mult_start, div_start, busy}, 3'b011);
        bad = 0;
        for (int k = 2; k <= 11; k++) begin
            tick();
            if (!busy || done || mult_start || div_start) bad++;
        end
        chk("div_wait_cycles", bad, 0);
        tick();
        chk("div_done_t12", {done, busy}, 2'b10);
        chk("div_hilo", {hi, lo}, {32'd2, 32'd14});
        noise = 1'b0;
        tick();
        chk("done_one_cycle", done, 1'b0);

        // Direct writes, then divide by zero
        mthi_wr = 1'b1; wr_data = 32'h11;
        tick();
        mthi_wr = 1'b0; mtlo_wr = 1'b1; wr_data = 32'h22;
        tick();
        mtlo_wr = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'h11, 32'h22});
        issue(1'b1, 32'd5, 32'd0);
        tick();
        op_start = 1'b0;
        chk("dz_pulse", {div_zero, busy, div_start, mult_start, done}, 5'b10000);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (busy || div_zero || div_start) bad++;
        end
        chk("dz_idle", bad, 0);
        chk("dz_hilo", {hi, lo}, {32'h11, 32'h22});

        mthi_wr = 1'b1; mtlo_wr = 1'b1; wr_data = 32'h5A5A_0F0F;
        tick();
        mthi_wr = 1'b0; mtlo_wr = 1'b0;
        chk("both_wr", {hi, lo}, {32'h5A5A_0F0F, 32'h5A5A_0F0F});

        // Timeout: multiplier never finishes
        m_dly = 0;
        issue(1'b0, 32'd3, 32'd4);
        tick();
        op_start = 1'b0;
        bad = 0;
        for (int k = 1; k <= 65; k++) begin
            if (!busy || timeout_err || done) bad++;
            tick();
        end
        chk("tmo_wait", bad, 0);
        chk("tmo_t66", {timeout_err, busy, done}, 3'b100);
        chk("tmo_hilo", {hi, lo}, {32'h5A5A_0F0F, 32'h5A5A_0F0F});
        m_dly = 5;
        issue(1'b0, 32'd3, 32'd4);
        tick();
        op_start = 1'b0;
        chk("tmo_one_cycle", timeout_err, 1'b0);
        wait_done(40, cyc);
        chk("post_tmo_done", cyc > 0, 1'b1);
        chk("post_tmo_hilo", {hi, lo}, {32'd0, 32'd12});

        // Write and second op_start during WAIT are ignored
        m_dly = 8;
        tick();
        issue(1'b0, 32'h0001_0000, 32'h0001_0000);
        tick(2);
        mthi_wr = 1'b1; wr_data = 32'hAAAA;
        issue(1'b1, 32'd9, 32'd3);
        tick();
        mthi_wr = 1'b0; op_start = 1'b0;
        chk("wait_wr_ignored", hi, 32'd0);
        chk("wait_unit_held", {unit_a, unit_b}, {32'h0001_0000, 32'h0001_0000});
        wait_done(40, cyc);
        chk("wait_first_lands", cyc, 8);
        chk("wait_hilo", {hi, lo}, {32'd1, 32'd0});
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy || div_start || mult_start) bad++;
        end
        chk("no_queued_op", bad, 0);

        // Write coinciding with an accepted op_start
        mthi_wr = 1'b1; mtlo_wr = 1'b1; wr_data = 32'h777;
        issue(1'b0, 32'd2, 32'd3);
        tick();
        mthi_wr = 1'b0; mtlo_wr = 1'b0; op_start = 1'b0;
        chk("coincide_wr", {hi, lo, busy}, {32'h777, 32'h777, 1'b1});
        wait_done(40, cyc);
        chk("coincide_result", {hi, lo}, {32'd0, 32'd6});

        // Reset during WAIT of a long mult; later stale done must not land
        m_dly = 32;
        tick();
        issue(1'b0, 32'd6, 32'd7);
        tick();
        op_start = 1'b0;
        tick(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_outputs", {hi, lo, unit_a, unit_b}, 128'h0);
        chk("abort_flags", {mult_start, div_start, busy, done, div_zero, timeout_err}, 0);
        cnt = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || timeout_err || busy) bad++;
            if (m_done) cnt++;
        end
        chk("stale_done_seen", cnt > 0, 1'b1);
        chk("abort_quiet", bad, 0);
        chk("stale_hilo", {hi, lo}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
